// File: rtl/freq_period_meter.sv
// Period and high-time meter for an asynchronous pin input.
// Counts CLOCK cycles between synchronized rising edges of SIG_IN.
module freq_period_meter #(
  parameter int CNT_WIDTH   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLOCK,
  input  logic                 RESETn,
  input  logic                 ENABLE,
  input  logic                 SIG_IN,
  output logic [CNT_WIDTH-1:0] PERIOD,
  output logic [CNT_WIDTH-1:0] HIGH_TIME,
  output logic                 VALID,
  output logic                 OVERFLOW,
  output logic                 BUSY
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   sig;
  logic                   rise;
  logic                   fall;
  logic                   sat;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   high_lat;

  // Synchronizer keeps running while disabled so re-enable sees no false edge
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SIG_IN};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig  = sync_q[SYNC_STAGES-1];
  assign rise = sig & ~prev;
  assign fall = ~sig & prev;
  assign sat  = (cnt == CNT_MAX);

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      high_lat  <= '0;
      PERIOD    <= '0;
      HIGH_TIME <= '0;
      VALID     <= 1'b0;
      OVERFLOW  <= 1'b0;
      BUSY      <= 1'b0;
    end else if (!ENABLE) begin
      state    <= IDLE;
      cnt      <= '0;
      high_lat <= '0;
      VALID    <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (rise) begin
        cnt <= CNT_ONE;
      end else if (!sat) begin
        cnt <= cnt + CNT_ONE;
      end
      unique case (state)
        IDLE: begin
          if (rise) begin
            state    <= MEASURE;
            BUSY     <= 1'b1;
            high_lat <= '0;
          end
        end
        MEASURE: begin
          // A rise on the saturating cycle still completes the period
          if (rise) begin
            PERIOD    <= cnt;
            HIGH_TIME <= high_lat;
            VALID     <= 1'b1;
            OVERFLOW  <= 1'b0;
            high_lat  <= '0;
          end else if (sat) begin
            OVERFLOW <= 1'b1;
            state    <= IDLE;
            BUSY     <= 1'b0;
          end
          if (fall) begin
            high_lat <= cnt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_period_meter.sv
// Randomized bench for freq_period_meter with an edge-time model.
// Expected results come from SIG_IN edge timestamps, not RTL state.
module tb_freq_period_meter;

  localparam int CW   = 8;
  localparam int SYNC = 2;
  localparam int MAX  = (1 << CW) - 1;

  typedef struct {
    int p;
    int h;
    int c;
  } meas_t;

  logic          CLOCK  = 1'b0;
  logic          RESETn = 1'b0;
  logic          ENABLE = 1'b0;
  logic          SIG_IN = 1'b0;
  logic [CW-1:0] PERIOD;
  logic [CW-1:0] HIGH_TIME;
  logic          VALID;
  logic          OVERFLOW;
  logic          BUSY;

  int    cyc   = 0;
  int    n_vec = 0;
  int    n_err = 0;
  meas_t exp_q[$];
  meas_t got_q[$];

  bit armed      = 0;
  bit fell       = 0;
  int last_rise  = 0;
  int last_fall  = 0;
  int mdl_period = 0;
  int mdl_high   = 0;
  bit mdl_ovf    = 0;

  freq_period_meter #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLOCK    (CLOCK),
    .RESETn   (RESETn),
    .ENABLE   (ENABLE),
    .SIG_IN   (SIG_IN),
    .PERIOD   (PERIOD),
    .HIGH_TIME(HIGH_TIME),
    .VALID    (VALID),
    .OVERFLOW (OVERFLOW),
    .BUSY     (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Every cycle with VALID high is logged, so a stretched pulse shows up
  always @(negedge CLOCK) begin
    if (VALID === 1'b1) begin
      got_q.push_back('{int'(PERIOD), int'(HIGH_TIME), cyc});
    end
  end

  // A measurement closes when a rise follows the arming rise by at most
  // MAX cycles; the sync pipeline delay cancels between the two edges.
  task automatic mdl_rise(input int t);
    meas_t e;
    if (armed) begin
      if (t - last_rise <= MAX) begin
        e.p = t - last_rise;
        e.h = fell ? (last_fall - last_rise) : 0;
        e.c = t + SYNC + 1;
        exp_q.push_back(e);
        mdl_period = e.p;
        mdl_high   = e.h;
        mdl_ovf    = 0;
      end else begin
        mdl_ovf = 1;
      end
    end
    armed     = 1;
    last_rise = t;
    fell      = 0;
  endtask

  task automatic step(input bit v);
    @(negedge CLOCK);
    if (v && !SIG_IN) mdl_rise(cyc);
    if (!v && SIG_IN) begin
      fell      = 1;
      last_fall = cyc;
    end
    SIG_IN = v;
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK);
    n_vec++;
    if (PERIOD !== '0) begin
      n_err++;
      $display("FAIL reset.period got %0d want 0", PERIOD);
    end
    n_vec++;
    if (HIGH_TIME !== '0) begin
      n_err++;
      $display("FAIL reset.high got %0d want 0", HIGH_TIME);
    end
    n_vec++;
    if (VALID !== 1'b0) begin
      n_err++;
      $display("FAIL reset.valid got %b want 0", VALID);
    end
    n_vec++;
    if (OVERFLOW !== 1'b0) begin
      n_err++;
      $display("FAIL reset.overflow got %b want 0", OVERFLOW);
    end
    n_vec++;
    if (BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL reset.busy got %b want 0", BUSY);
    end
    RESETn = 1'b1;
    ENABLE = 1'b1;
  endtask

  task automatic test_single();
    hold(1'b0, 5);
    wave(30, 70, 4);
    step(1'b1);
    hold(1'b1, SYNC + 3);
    n_vec++;
    if (BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL single.busy got %b want 1", BUSY);
    end
    n_vec++;
    if (OVERFLOW !== 1'b0) begin
      n_err++;
      $display("FAIL single.overflow got %b want 0", OVERFLOW);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL single.count got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i].p !== exp_q[i].p || got_q[i].h !== exp_q[i].h ||
          got_q[i].c !== exp_q[i].c) begin
        n_err++;
        $display("FAIL single.meas%0d got p=%0d h=%0d cyc=%0d want p=%0d h=%0d cyc=%0d",
                 i, got_q[i].p, got_q[i].h, got_q[i].c,
                 exp_q[i].p, exp_q[i].h, exp_q[i].c);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int w = 0; w < 20; w++) begin
      wave($urandom_range(1, 130), $urandom_range(1, 130),
           $urandom_range(1, 3));
    end
    step(1'b1);
    hold(1'b1, SYNC + 5);
    n_vec++;
    if (OVERFLOW !== mdl_ovf) begin
      n_err++;
      $display("FAIL random.overflow got %b want %b", OVERFLOW, mdl_ovf);
    end
    n_vec++;
    if (PERIOD !== mdl_period[CW-1:0]) begin
      n_err++;
      $display("FAIL random.period got %0d want %0d", PERIOD, mdl_period);
    end
    n_vec++;
    if (HIGH_TIME !== mdl_high[CW-1:0]) begin
      n_err++;
      $display("FAIL random.high got %0d want %0d", HIGH_TIME, mdl_high);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL random.count got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i].p !== exp_q[i].p || got_q[i].h !== exp_q[i].h ||
          got_q[i].c !== exp_q[i].c) begin
        n_err++;
        $display("FAIL random.meas%0d got p=%0d h=%0d cyc=%0d want p=%0d h=%0d cyc=%0d",
                 i, got_q[i].p, got_q[i].h, got_q[i].c,
                 exp_q[i].p, exp_q[i].h, exp_q[i].c);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_boundary();
    hold(1'b0, 5);
    wave(100, 155, 2);
    wave(100, 156, 1);
    hold(1'b0, 20);
    n_vec++;
    if (OVERFLOW !== 1'b1) begin
      n_err++;
      $display("FAIL boundary.ovf_set got %b want 1", OVERFLOW);
    end
    n_vec++;
    if (BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL boundary.busy got %b want 0", BUSY);
    end
    n_vec++;
    if (PERIOD !== 8'd255) begin
      n_err++;
      $display("FAIL boundary.period_hold got %0d want 255", PERIOD);
    end
    wave(25, 25, 2);
    step(1'b1);
    hold(1'b1, SYNC + 3);
    n_vec++;
    if (OVERFLOW !== 1'b0) begin
      n_err++;
      $display("FAIL boundary.ovf_clear got %b want 0", OVERFLOW);
    end
    n_vec++;
    if (PERIOD !== 8'd50 || HIGH_TIME !== 8'd25) begin
      n_err++;
      $display("FAIL boundary.p50 got p=%0d h=%0d want p=50 h=25",
               PERIOD, HIGH_TIME);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL boundary.count got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i].p !== exp_q[i].p || got_q[i].h !== exp_q[i].h ||
          got_q[i].c !== exp_q[i].c) begin
        n_err++;
        $display("FAIL boundary.meas%0d got p=%0d h=%0d cyc=%0d want p=%0d h=%0d cyc=%0d",
                 i, got_q[i].p, got_q[i].h, got_q[i].c,
                 exp_q[i].p, exp_q[i].h, exp_q[i].c);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_enable_reset();
    hold(1'b0, 5);
    wave(30, 70, 2);
    hold(1'b1, 30);
    hold(1'b0, 10);
    ENABLE = 1'b0;
    armed  = 0;
    step(1'b0);
    n_vec++;
    if (BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL enable.busy got %b want 0", BUSY);
    end
    n_vec++;
    if (PERIOD !== mdl_period[CW-1:0] || HIGH_TIME !== mdl_high[CW-1:0]) begin
      n_err++;
      $display("FAIL enable.hold got p=%0d h=%0d want p=%0d h=%0d",
               PERIOD, HIGH_TIME, mdl_period, mdl_high);
    end
    hold(1'b0, 20);
    ENABLE = 1'b1;
    wave(30, 70, 3);
    step(1'b1);
    hold(1'b1, 30);
    hold(1'b0, 10);
    RESETn     = 1'b0;
    armed      = 0;
    mdl_period = 0;
    mdl_high   = 0;
    mdl_ovf    = 0;
    #1;
    n_vec++;
    if (PERIOD !== '0 || HIGH_TIME !== '0 || VALID !== 1'b0 ||
        OVERFLOW !== 1'b0 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL midreset.outputs got p=%0d h=%0d v=%b o=%b b=%b want all 0",
               PERIOD, HIGH_TIME, VALID, OVERFLOW, BUSY);
    end
    hold(1'b0, 3);
    RESETn = 1'b1;
    wave(30, 70, 2);
    step(1'b1);
    hold(1'b1, SYNC + 3);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL enable_reset.count got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i].p !== exp_q[i].p || got_q[i].h !== exp_q[i].h ||
          got_q[i].c !== exp_q[i].c) begin
        n_err++;
        $display("FAIL enable_reset.meas%0d got p=%0d h=%0d cyc=%0d want p=%0d h=%0d cyc=%0d",
                 i, got_q[i].p, got_q[i].h, got_q[i].c,
                 exp_q[i].p, exp_q[i].h, exp_q[i].c);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_min_pulse();
    hold(1'b0, 5);
    wave(1, 1, 6);
    step(1'b1);
    hold(1'b1, 300);
    n_vec++;
    if (OVERFLOW !== 1'b1) begin
      n_err++;
      $display("FAIL minpulse.overflow got %b want 1", OVERFLOW);
    end
    n_vec++;
    if (PERIOD !== 8'd2 || HIGH_TIME !== 8'd1) begin
      n_err++;
      $display("FAIL minpulse.hold got p=%0d h=%0d want p=2 h=1",
               PERIOD, HIGH_TIME);
    end
    hold(1'b0, 5);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL minpulse.count got %0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i].p !== exp_q[i].p || got_q[i].h !== exp_q[i].h ||
          got_q[i].c !== exp_q[i].c) begin
        n_err++;
        $display("FAIL minpulse.meas%0d got p=%0d h=%0d cyc=%0d want p=%0d h=%0d cyc=%0d",
                 i, got_q[i].p, got_q[i].h, got_q[i].c,
                 exp_q[i].p, exp_q[i].h, exp_q[i].c);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_boundary();
    test_enable_reset();
    test_min_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
